// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver types and frame constants.
package ps2_pkg;
  localparam int   DATA_BITS = 8;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_e;
endpackage

// File: rtl/ps2_rx_if.sv
// Received-byte bus from the PS/2 receiver to its consumer.
interface ps2_rx_if;
  logic [7:0] d_o;
  logic       d_valid;
  logic       parity_err;
  logic       frame_err;

  modport master (output d_o, d_valid, parity_err, frame_err);
  modport slave  (input  d_o, d_valid, parity_err, frame_err);
endinterface

// File: rtl/ps2_filter.sv
// Pad synchronizers, ps2_clk glitch filter and falling-edge strobe.
module ps2_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic fall_o,
  output logic data_o
);
  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    clk_sync, dat_sync;
  logic          filt;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      filt     <= 1'b1;
      cnt      <= '0;
      fall_o   <= 1'b0;
      data_o   <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
      data_o   <= dat_sync[1];
      fall_o   <= 1'b0;
      // cnt tracks how many consecutive samples disagree with the filtered level
      if (clk_sync[1] != filt) begin
        if (cnt == CW'(FILTER_LEN - 1)) begin
          filt   <= clk_sync[1];
          cnt    <= '0;
          fall_o <= filt;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end
endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver: start, 8 data LSB first, odd parity, stop.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ      = 50000000,
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic     clk,
  input  logic     internal_reset_n,
  input  logic     ps2_clk,
  input  logic     ps2_data,
  ps2_rx_if.master rx
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  // CLK_HZ only documents the clock the timing parameters were chosen for
  wire unused_clk_hz = ^CLK_HZ;

  logic fall, sample;

  ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
    .clk      (clk),
    .rst_n    (internal_reset_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .fall_o   (fall),
    .data_o   (sample)
  );

  ps2_state_e    state_q, state_n;
  logic [2:0]    bit_q, bit_n;
  logic [7:0]    shift_q, shift_n;
  logic          par_q, par_n;
  logic [TW-1:0] tcnt_q, tcnt_n;
  logic [7:0]    d_q, d_n;
  logic          dv_q, dv_n, pe_q, pe_n, fe_q, fe_n;

  always_ff @(posedge clk or negedge internal_reset_n) begin
    if (!internal_reset_n) begin
      state_q <= IDLE;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tcnt_q  <= '0;
      d_q     <= '0;
      dv_q    <= 1'b0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_n;
      bit_q   <= bit_n;
      shift_q <= shift_n;
      par_q   <= par_n;
      tcnt_q  <= tcnt_n;
      d_q     <= d_n;
      dv_q    <= dv_n;
      pe_q    <= pe_n;
      fe_q    <= fe_n;
    end
  end

  always_comb begin
    state_n = state_q;
    bit_n   = bit_q;
    shift_n = shift_q;
    par_n   = par_q;
    d_n     = d_q;
    dv_n    = 1'b0;
    pe_n    = 1'b0;
    fe_n    = 1'b0;
    tcnt_n  = (state_q == IDLE || fall) ? '0 : tcnt_q + TW'(1);

    case (state_q)
      IDLE: if (fall && sample == START_BIT) begin
        state_n = DATA;
        bit_n   = '0;
        shift_n = '0;
      end
      DATA: if (fall) begin
        shift_n = {sample, shift_q[7:1]};
        bit_n   = bit_q + 3'd1;
        if (bit_q == 3'(DATA_BITS - 1)) state_n = PARITY;
      end
      PARITY: if (fall) begin
        par_n   = sample;
        state_n = STOP;
      end
      STOP: if (fall) begin
        state_n = IDLE;
        // a bad stop bit outranks a parity failure
        if (sample != STOP_BIT)      fe_n = 1'b1;
        else if (^{shift_q, par_q}) begin
          d_n  = shift_q;
          dv_n = 1'b1;
        end else                     pe_n = 1'b1;
      end
      default: state_n = IDLE;
    endcase

    // stalled mid-frame: drop the partial byte
    if (state_q != IDLE && !fall && tcnt_q == TW'(TIMEOUT_CYC - 1)) begin
      state_n = IDLE;
      fe_n    = 1'b1;
    end
  end

  assign rx.d_o        = d_q;
  assign rx.d_valid    = dv_q;
  assign rx.parity_err = pe_q;
  assign rx.frame_err  = fe_q;
endmodule

// File: tb/tb_ps2_rx.sv
// Directed frame-level bench for ps2_rx with a time-scaled PS/2 clock.
module tb_ps2_rx;
  localparam int FLT  = 4;
  localparam int TMO  = 200;
  localparam int HALF = 20;

  logic clk = 1'b0;
  logic internal_reset_n = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;

  ps2_rx_if rx_if ();

  ps2_rx #(.CLK_HZ(100000000), .FILTER_LEN(FLT), .TIMEOUT_CYC(TMO)) dut (
    .clk              (clk),
    .internal_reset_n (internal_reset_n),
    .ps2_clk          (ps2_clk),
    .ps2_data         (ps2_data),
    .rx               (rx_if)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int cnt_dv = 0, cnt_pe = 0, cnt_fe = 0, viol = 0;
  logic [7:0] prev_do = 8'h00;

  always @(negedge clk) begin
    if (internal_reset_n) begin
      if (rx_if.d_valid)    cnt_dv++;
      if (rx_if.parity_err) cnt_pe++;
      if (rx_if.frame_err)  cnt_fe++;
      if (int'(rx_if.d_valid) + int'(rx_if.parity_err) + int'(rx_if.frame_err) > 1) viol++;
      if (rx_if.d_o !== prev_do && !rx_if.d_valid) viol++;
    end
    prev_do = rx_if.d_o;
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_counts();
    @(posedge clk);
    cnt_dv = 0; cnt_pe = 0; cnt_fe = 0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] d, input bit flip, input bit stop);
    logic [10:0] f;
    f[0]   = 1'b0;
    f[8:1] = d;
    f[9]   = (~^d) ^ flip;
    f[10]  = stop;
    return f;
  endfunction

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = f[i];
      wait_cyc(HALF);
      ps2_clk = 1'b0;
      wait_cyc(HALF);
      ps2_clk = 1'b1;
    end
    wait_cyc(HALF);
    ps2_data = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    bit         flip;
    bit         stop;
    int         exp_dv;
    int         exp_pe;
    int         exp_fe;
    logic [7:0] exp_do;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{8'h1C, 1'b0, 1'b1, 1, 0, 0, 8'h1C};
    vecs[1] = '{8'hF0, 1'b0, 1'b1, 1, 0, 0, 8'hF0};
    vecs[2] = '{8'h1C, 1'b0, 1'b1, 1, 0, 0, 8'h1C};
    vecs[3] = '{8'h1C, 1'b1, 1'b1, 0, 1, 0, 8'h1C};
    vecs[4] = '{8'h5A, 1'b0, 1'b0, 0, 0, 1, 8'h1C};
    vecs[5] = '{8'h5A, 1'b1, 1'b0, 0, 0, 1, 8'h1C};
    vecs[6] = '{8'h29, 1'b0, 1'b1, 1, 0, 0, 8'h29};

    wait_cyc(3);
    #1;
    check("rst_d_o", int'(rx_if.d_o), 0);
    check("rst_pulses", int'({rx_if.d_valid, rx_if.parity_err, rx_if.frame_err}), 0);
    internal_reset_n = 1'b1;
    clear_counts();
    wait_cyc(30);
    check("post_rst_d_o", int'(rx_if.d_o), 0);
    check("post_rst_pulses", cnt_dv + cnt_pe + cnt_fe, 0);

    for (int v = 0; v < 7; v++) begin
      clear_counts();
      send_bits(mk_frame(vecs[v].data, vecs[v].flip, vecs[v].stop), 11);
      wait_cyc(30);
      check($sformatf("v%0d_d_valid", v), cnt_dv, vecs[v].exp_dv);
      check($sformatf("v%0d_parity_err", v), cnt_pe, vecs[v].exp_pe);
      check($sformatf("v%0d_frame_err", v), cnt_fe, vecs[v].exp_fe);
      check($sformatf("v%0d_d_o", v), int'(rx_if.d_o), int'(vecs[v].exp_do));
    end

    // short low glitch while idle must not look like a start bit
    clear_counts();
    ps2_data = 1'b0;
    wait_cyc(5);
    ps2_clk = 1'b0;
    wait_cyc(FLT - 1);
    ps2_clk = 1'b1;
    wait_cyc(5);
    ps2_data = 1'b1;
    wait_cyc(50);
    check("glitch_pulses", cnt_dv + cnt_pe + cnt_fe, 0);
    send_bits(mk_frame(8'h1C, 1'b0, 1'b1), 11);
    wait_cyc(30);
    check("glitch_next_dv", cnt_dv, 1);
    check("glitch_next_err", cnt_pe + cnt_fe, 0);
    check("glitch_next_d_o", int'(rx_if.d_o), 8'h1C);

    // ps2_clk stalls after four data bits
    clear_counts();
    send_bits(mk_frame(8'h33, 1'b0, 1'b1), 5);
    wait_cyc(100);
    check("tmo_early_fe", cnt_fe, 0);
    wait_cyc(150);
    check("tmo_fe", cnt_fe, 1);
    check("tmo_other", cnt_dv + cnt_pe, 0);
    clear_counts();
    send_bits(mk_frame(8'h5A, 1'b0, 1'b1), 11);
    wait_cyc(30);
    check("tmo_next_dv", cnt_dv, 1);
    check("tmo_next_err", cnt_pe + cnt_fe, 0);
    check("tmo_next_d_o", int'(rx_if.d_o), 8'h5A);

    // reset lands mid-frame after start plus four data bits
    clear_counts();
    send_bits(mk_frame(8'hC3, 1'b0, 1'b1), 5);
    internal_reset_n = 1'b0;
    #1;
    check("midrst_d_o", int'(rx_if.d_o), 0);
    wait_cyc(4);
    internal_reset_n = 1'b1;
    wait_cyc(60);
    check("midrst_pulses", cnt_dv + cnt_pe + cnt_fe, 0);
    send_bits(mk_frame(8'h29, 1'b0, 1'b1), 11);
    wait_cyc(30);
    check("midrst_next_dv", cnt_dv, 1);
    check("midrst_next_err", cnt_pe + cnt_fe, 0);
    check("midrst_next_d_o", int'(rx_if.d_o), 8'h29);

    check("excl_and_hold_violations", viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
